// File: rtl/cpu_pkg.sv
// Shared Thumb core definitions: datapath widths, sequencer state encoding and the uop format
// exchanged between decode and execute.
package cpu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 16;
  localparam logic [XLEN-1:0] PC_STEP = 32'd2;

  // Binary state encoding, kept as plain constants so older blocks can compare against them.
  typedef logic [2:0] seq_state_t;
  localparam seq_state_t FETCH  = 3'd0;
  localparam seq_state_t WAIT   = 3'd1;
  localparam seq_state_t DECODE = 3'd2;
  localparam seq_state_t CHECK  = 3'd3;
  localparam seq_state_t EXEC   = 3'd4;
  localparam seq_state_t HALT   = 3'd5;

  typedef enum logic [3:0] {
    UopNop,
    UopAlu,
    UopShift,
    UopLoad,
    UopStore,
    UopBranch,
    UopBranchCond,
    UopSys
  } uop_op_t;

  typedef struct packed {
    uop_op_t    op;
    logic [2:0] rd;
    logic [2:0] rn;
    logic [2:0] rm;
    logic [7:0] imm;
  } uop_t;

  // Redirect targets are halfword aligned; bit 0 (Thumb interworking bit) is dropped.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] target);
    return {target[XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/thumb_fetch_sequencer_if.sv
// Bundle between the fetch sequencer, instruction memory, decoder and execute stage.
// master = sequencer side, slave = memory/decode/execute side.
interface thumb_fetch_sequencer_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] dec_instr;
  logic               dec_explose;
  logic               ex_start;
  logic               ex_done;
  logic               br_taken;
  logic [XLEN-1:0]    br_target;

  modport master (
    output imem_req, imem_addr, dec_instr, ex_start,
    input  imem_gnt, imem_rvalid, imem_rdata, dec_explose, ex_done, br_taken, br_target
  );

  modport slave (
    input  imem_req, imem_addr, dec_instr, ex_start,
    output imem_gnt, imem_rvalid, imem_rdata, dec_explose, ex_done, br_taken, br_target
  );

endinterface

// File: rtl/thumb_fetch_sequencer.sv
// Thumb core sequencer: fetch, decode handoff, execute launch, PC update, halt on fault.
// Define SEQ_HALT_ON_ILLEGAL_EN to halt on an illegal instruction instead of skipping it.
module thumb_fetch_sequencer import cpu_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     EX_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  thumb_fetch_sequencer_if.master        bus,
  output logic [XLEN-1:0]                pc,
  output logic                           halted
);

  localparam int unsigned CNT_W = (EX_TIMEOUT > 1) ? $clog2(EX_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EX_TIMEOUT - 1);

  seq_state_t         state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Keeps imem_req low while reset is held; fetching begins the cycle after release.
  logic               run_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FETCH: begin
        if (run_q && bus.imem_gnt) begin
          if (bus.imem_rvalid) begin
            instr_d = bus.imem_rdata;
            state_d = DECODE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          instr_d = bus.imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: state_d = CHECK;
      CHECK: begin
        cnt_d = '0;
        if (bus.dec_explose) begin
`ifdef SEQ_HALT_ON_ILLEGAL_EN
          state_d = HALT;
`else
          pc_d    = pc_q + PC_STEP;
          state_d = FETCH;
`endif
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        // A completion in the expiry cycle still retires the instruction.
        if (bus.ex_done) begin
          pc_d    = bus.br_taken ? align_target(bus.br_target) : pc_q + PC_STEP;
          state_d = FETCH;
        end else if (EX_TIMEOUT != 0) begin
          if (cnt_q == CNT_LAST) begin
            state_d = HALT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HALT: state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
    end
  end

  assign bus.imem_req  = run_q && (state_q == FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.dec_instr = instr_q;
  assign bus.ex_start  = (state_q == CHECK) && !bus.dec_explose;
  assign pc            = pc_q;
  assign halted        = (state_q == HALT);

endmodule

// File: tb/tb_thumb_fetch_sequencer.sv
// Randomized bench for thumb_fetch_sequencer with a transaction-level PC/instruction model.
module tb_thumb_fetch_sequencer;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam int unsigned TMO    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic        halted;

  thumb_fetch_sequencer_if bus ();

  thumb_fetch_sequencer #(
    .RESET_PC   (RST_PC),
    .EX_TIMEOUT (TMO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .pc     (pc),
    .halted (halted)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] pc_m;
  logic [15:0] instr_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.dec_explose = 1'b0;
    bus.ex_done     = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_target   = '0;
  endtask

  // Asynchronous assertion mid-cycle; outputs must take reset values without a clock edge.
  task automatic do_reset();
    clear_inputs();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_pc", pc, RST_PC);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_req", bus.imem_req, 0);
    check_eq("rst_ex_start", bus.ex_start, 0);
    check_eq("rst_dec_instr", bus.dec_instr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    pc_m    = RST_PC;
    instr_m = '0;
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req) break;
      tick();
    end
    check_eq("fetch_req", bus.imem_req, 1);
  endtask

  // ex_at: EXEC cycle (1-based) carrying ex_done; 0 = never; negative = reset in EXEC cycle 3.
  task automatic run_instr(input int gnt_dly, input int r_dly, input bit illegal,
                           input int ex_at, input bit br, input logic [31:0] tgt);
    logic [15:0] d;
    d = 16'($urandom);
    wait_req();
    check_eq("fetch_addr", bus.imem_addr, pc_m);
    for (int i = 0; i < gnt_dly; i++) begin
      bus.ex_done = 1'($urandom_range(0, 1));
      tick();
      check_eq("req_hold", bus.imem_req, 1);
      check_eq("addr_hold", bus.imem_addr, pc_m);
    end
    bus.ex_done     = 1'b0;
    bus.imem_gnt    = 1'b1;
    bus.imem_rdata  = d;
    bus.imem_rvalid = (r_dly == 0);
    tick();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    for (int i = 1; i <= r_dly; i++) begin
      check_eq("req_drop", bus.imem_req, 0);
      check_eq("instr_hold", bus.dec_instr, 32'(instr_m));
      if (i == r_dly) bus.imem_rvalid = 1'b1;
      tick();
      bus.imem_rvalid = 1'b0;
    end
    instr_m = d;
    check_eq("dec_instr", bus.dec_instr, 32'(d));
    check_eq("ex_start_decode", bus.ex_start, 0);
    bus.dec_explose = illegal;
    tick();
    check_eq("ex_start_check", bus.ex_start, 32'(!illegal));
    tick();
    bus.dec_explose = 1'b0;
    if (illegal) begin
`ifdef SEQ_HALT_ON_ILLEGAL_EN
      check_eq("ill_halted", halted, 1);
      check_eq("ill_pc", pc, pc_m);
`else
      pc_m = pc_m + 32'd2;
      check_eq("ill_not_halted", halted, 0);
      check_eq("ill_skip_pc", pc, pc_m);
`endif
      return;
    end
    for (int k = 1; k <= int'(TMO); k++) begin
      if (k == 1) check_eq("ex_start_pulse", bus.ex_start, 0);
      if (ex_at < 0 && k == 3) begin
        do_reset();
        return;
      end
      if (k == ex_at) begin
        bus.ex_done   = 1'b1;
        bus.br_taken  = br;
        bus.br_target = tgt;
        tick();
        bus.ex_done  = 1'b0;
        bus.br_taken = 1'b0;
        pc_m = br ? {tgt[31:1], 1'b0} : pc_m + 32'd2;
        check_eq("pc_update", pc, pc_m);
        check_eq("exec_no_halt", halted, 0);
        return;
      end
      bus.imem_rvalid = 1'($urandom_range(0, 1));
      tick();
      bus.imem_rvalid = 1'b0;
    end
    check_eq("timeout_halt", halted, 1);
    check_eq("timeout_pc", pc, pc_m);
  endtask

  task automatic sticky_halt();
    for (int i = 0; i < 5; i++) begin
      bus.imem_gnt    = 1'($urandom_range(0, 1));
      bus.imem_rvalid = 1'($urandom_range(0, 1));
      bus.ex_done     = 1'($urandom_range(0, 1));
      bus.br_taken    = 1'b1;
      bus.dec_explose = 1'($urandom_range(0, 1));
      tick();
      check_eq("halt_sticky", halted, 1);
      check_eq("halt_req", bus.imem_req, 0);
      check_eq("halt_start", bus.ex_start, 0);
      check_eq("halt_pc", pc, pc_m);
    end
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ill;
    clear_inputs();
    #3;
    do_reset();

    for (int i = 0; i < 3; i++) run_instr(0, 1, 1'b0, 1, 1'b0, '0);
    run_instr(0, 1, 1'b0, 1, 1'b1, 32'h0000_0101);
    run_instr(3, 2, 1'b0, 2, 1'b0, '0);
    run_instr(0, 0, 1'b0, 1, 1'b0, '0);
    run_instr(0, 1, 1'b0, int'(TMO), 1'b0, '0);

    for (int i = 0; i < 30; i++) begin
`ifdef SEQ_HALT_ON_ILLEGAL_EN
      ill = 1'b0;
`else
      ill = ($urandom_range(0, 7) == 0);
`endif
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ill,
                int'($urandom_range(1, TMO)), ($urandom_range(0, 3) == 0), $urandom);
    end

    run_instr(0, 1, 1'b1, 1, 1'b0, '0);
`ifdef SEQ_HALT_ON_ILLEGAL_EN
    sticky_halt();
    do_reset();
`endif
    run_instr(1, 1, 1'b0, 1, 1'b0, '0);

    run_instr(0, 1, 1'b0, 0, 1'b0, '0);
    sticky_halt();
    do_reset();

    run_instr(0, 1, 1'b0, 1, 1'b1, 32'hFFFF_FFFF);
    run_instr(0, 1, 1'b0, 1, 1'b0, '0);
    run_instr(0, 1, 1'b0, 1, 1'b0, '0);
    run_instr(1, 1, 1'b0, -1, 1'b0, '0);
    run_instr(0, 1, 1'b0, 1, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
